// File: rtl/mem_pkg.sv
// Shared constants for the valid/ready single-port memory.
package mem_pkg;

    localparam int unsigned MEM_WIDTH      = 16;
    localparam int unsigned MEM_DEPTH      = 16;
    localparam int unsigned MEM_ADDR_WIDTH = 4;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Register-file storage with a single-edge synchronous clear, a write enable
// and a registered read port; addresses outside DEPTH never touch the array.
module mem_array #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             in_range_c;

    assign in_range_c = (32'(addr_i) < DEPTH);

    // Out-of-range reads return zero instead of indexing past the array.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            if (we_i && in_range_c) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= in_range_c ? mem_q[addr_i] : '0;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_array

// File: rtl/sync_valid_ready_mem.sv
// Single-port synchronous RAM behind a valid/ready request handshake.
// The block never back-pressures: ready rises one edge after reset and stays high.
module sync_valid_ready_mem
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = MEM_WIDTH,
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    input  logic                  valid,
    output logic                  ready
);

    logic ready_d;
    logic ready_q;
    logic accept_c;
    logic we_c;
    logic re_c;

    always_comb begin
        ready_d = ready_q;
        if (res) begin
            ready_d = 1'b0;
        end else begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ready_q <= ready_d;
    end

    // Reset wins over a coincident request.
    assign accept_c = valid && ready_q && !res;
    assign we_c     = accept_c && (wr_rd == WR);
    assign re_c     = accept_c && (wr_rd == RD);

    mem_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .clr_i   (res),
        .we_i    (we_c),
        .re_i    (re_c),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign ready = ready_q;

endmodule : sync_valid_ready_mem

// File: tb/tb_sync_valid_ready_mem.sv
// Directed self-checking bench for sync_valid_ready_mem (DEPTH=16 and DEPTH=12 instances).
module tb_sync_valid_ready_mem;

    logic        clk;
    logic        res;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        valid;
    logic [15:0] rdata;
    logic        ready;
    logic [15:0] rdata12;
    logic        ready12;

    int n_checks;
    int n_fail;

    sync_valid_ready_mem #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .res   (res),
        .wr_rd (wr_rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .valid (valid),
        .ready (ready)
    );

    sync_valid_ready_mem #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4)) dut12 (
        .clk   (clk),
        .res   (res),
        .wr_rd (wr_rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata12),
        .valid (valid),
        .ready (ready12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input int a, input logic [15:0] d);
        valid = v;
        wr_rd = w;
        addr  = 4'(a);
        wdata = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 0, 16'h0000);
        res = 1'b1;
        step();
        res = 1'b0;
        step();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 2, 16'h5A5A);
        res = 1'b1;
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", ready);
        end
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0000", rdata);
        end
        res = 1'b0;
        drive(1'b0, 1'b0, 0, 16'h0000);
        step();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_high: got %b want 1", ready);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, i, 16'h0000);
            step();
            n_checks++;
            if (rdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_read_zero addr=%0d: got %h want 0000", i, rdata);
            end
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 3, 16'hA5A5);
        step();
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL wr_keeps_rdata: got %h want 0000", rdata);
        end
        drive(1'b1, 1'b0, 3, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL write_read: got %h want a5a5", rdata);
        end
        drive(1'b0, 1'b0, 4, 16'h0000);
        step();
        step();
        n_checks++;
        if (rdata !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL rdata_hold: got %h want a5a5", rdata);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, i, 16'(i) * 16'h0101);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, i, 16'h0000);
            step();
            exp = 16'(i) * 16'h0101;
            n_checks++;
            if (rdata !== exp) begin
                n_fail++;
                $display("FAIL stream_read addr=%0d: got %h want %h", i, rdata, exp);
            end
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_valid_gating();
        do_reset();
        drive(1'b0, 1'b1, 5, 16'hFFFF);
        step();
        drive(1'b1, 1'b0, 5, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL gated_write: got %h want 0000", rdata);
        end
        drive(1'b1, 1'b1, 5, 16'h1111);
        step();
        drive(1'b1, 1'b1, 6, 16'h2222);
        step();
        drive(1'b1, 1'b0, 6, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h2222) begin
            n_fail++;
            $display("FAIL read6: got %h want 2222", rdata);
        end
        drive(1'b0, 1'b0, 5, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h2222) begin
            n_fail++;
            $display("FAIL gated_read_hold: got %h want 2222", rdata);
        end
        drive(1'b1, 1'b0, 5, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h1111) begin
            n_fail++;
            $display("FAIL read5: got %h want 1111", rdata);
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 2, 16'h1357);
        step();
        drive(1'b1, 1'b0, 2, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h1357) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want 1357", rdata);
        end
        drive(1'b1, 1'b1, 2, 16'h2468);
        step();
        drive(1'b1, 1'b0, 2, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h2468) begin
            n_fail++;
            $display("FAIL b2b_second: got %h want 2468", rdata);
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b1, 7, 16'h1234);
        step();
        drive(1'b1, 1'b0, 7, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL mid_pre_read: got %h want 1234", rdata);
        end
        drive(1'b1, 1'b1, 7, 16'h5555);
        res = 1'b1;
        step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_low: got %b want 0", ready);
        end
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_rdata_clear: got %h want 0000", rdata);
        end
        res = 1'b0;
        drive(1'b1, 1'b1, 7, 16'h9999);
        step();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready_high: got %b want 1", ready);
        end
        drive(1'b1, 1'b0, 7, 16'h0000);
        step();
        n_checks++;
        if (rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_read_lost: got %h want 0000", rdata);
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp;
        do_reset();
        n_checks++;
        if (ready12 !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_ready: got %b want 1", ready12);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, i, 16'hC000 | 16'(i));
            step();
        end
        drive(1'b1, 1'b1, 13, 16'hBEEF);
        step();
        drive(1'b1, 1'b1, 12, 16'hDEAD);
        step();
        drive(1'b1, 1'b0, 11, 16'h0000);
        step();
        n_checks++;
        if (rdata12 !== 16'hC00B) begin
            n_fail++;
            $display("FAIL oob_read11: got %h want c00b", rdata12);
        end
        drive(1'b1, 1'b0, 13, 16'h0000);
        step();
        n_checks++;
        if (rdata12 !== 16'h0000) begin
            n_fail++;
            $display("FAIL oob_read13: got %h want 0000", rdata12);
        end
        drive(1'b1, 1'b0, 12, 16'h0000);
        step();
        n_checks++;
        if (rdata12 !== 16'h0000) begin
            n_fail++;
            $display("FAIL oob_read12: got %h want 0000", rdata12);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, i, 16'h0000);
            step();
            exp = 16'hC000 | 16'(i);
            n_checks++;
            if (rdata12 !== exp) begin
                n_fail++;
                $display("FAIL oob_inrange addr=%0d: got %h want %h", i, rdata12, exp);
            end
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        res      = 1'b0;
        drive(1'b0, 1'b0, 0, 16'h0000);
        #2;
        test_reset();
        test_write_read();
        test_streaming();
        test_valid_gating();
        test_back_to_back();
        test_mid_reset();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_valid_ready_mem

// File: doc/sync_valid_ready_mem.md
Name: sync_valid_ready_mem

Overview:
- Single-port synchronous RAM with a valid/ready request handshake.
- A master presents wr_rd, addr, wdata and valid. The block accepts the request on a clock edge where valid and ready are both high.
- An accepted request either writes the array or returns a registered read in rdata.
- Sits behind the memory agent interface (signals clk, res, wr_rd, addr, wdata, rdata, valid, ready) as the sole storage target of the memory testbench environment.

Parameters:
- WIDTH, 16, data word width in bits (wdata, rdata, array entries).
- DEPTH, 16, number of words in the array.
- ADDR_WIDTH, 4, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- res  input  1  reset.
- wr_rd  input  1  request type: 1 = write, 0 = read.
- addr  input  ADDR_WIDTH  word address of the request.
- wdata  input  WIDTH  write data, sampled on write acceptance.
- rdata  output  WIDTH  registered read data.
- valid  input  1  master request strobe.
- ready  output  1  block can accept a request this cycle.

Behaviour:
- Interface (already decided): one clock, clk; reset res is synchronous and active-high.
- Reset (res=1 sampled at a rising edge):
  - ready <= 0, rdata <= 0.
  - Every array word <= 0; clearing completes in that single edge.
  - Reset has priority over any concurrent request; a request coincident with reset is dropped.
- Ready:
  - ready <= 1 on the first rising edge with res=0.
  - ready stays 1 until the next reset; the block never back-pressures otherwise.
- Acceptance: a request is accepted at a rising edge where res=0, valid=1 and ready=1. Requests with valid=0 are ignored, regardless of the other inputs.
- Write (wr_rd=1):
  - mem[addr] <= wdata at the accepting edge.
  - rdata is unchanged.
- Read (wr_rd=0):
  - rdata <= mem[addr] at the accepting edge, i.e. visible one cycle after acceptance.
  - rdata holds that value until the next accepted read or a reset.
- Back-to-back: one request per cycle sustained.
  - A read accepted the cycle after a write to the same address returns the new data.
  - There is no write-first bypass within a single edge; only one request exists per cycle.
- Out-of-range address (addr >= DEPTH):
  - A write is discarded with no array change.
  - A read sets rdata <= 0.
- Mid-operation reset:
  - All contents are lost and rdata returns to 0.
  - ready is low for the reset cycle(s) and returns high one edge after res falls.
- No X propagation: all outputs are defined from the first reset onward.

Decomposition:
- Package mem_pkg:
  - Default constants WIDTH=16, DEPTH=16, ADDR_WIDTH=4.
  - Request-type constants WR=1'b1, RD=1'b0.
- One sub-module is natural: mem_array, a parameterised register-file storage with a synchronous clear, a write-enable port and a registered read port.
- The top handles the handshake, address range check and ready generation.

Test Plan:
- Reset then idle: res=1 for 1 edge, then 0 -> rdata=0 and ready=0 during reset; ready=1 from the first edge after; a read of every address returns 0.
- Write then read: write addr=3 wdata=16'hA5A5 with valid=1, next cycle read addr=3 -> rdata=16'hA5A5 one cycle after read acceptance.
- Streaming: write addr 0..15 with data = addr*16'h0101 on consecutive cycles, then read 0..15 back-to-back -> rdata sequence 16'h0000, 16'h0101, ..., 16'h0F0F, each one cycle after its read.
- valid gating: wr_rd=1 addr=5 wdata=16'hFFFF with valid=0, then read addr=5 -> rdata=0; rdata stays unchanged while valid=0.
- Mid-operation reset: write addr=7 16'h1234, assert res for one edge, read addr=7 -> rdata=0; ready low during reset and high one edge after.
- Out-of-range (DEPTH=12 instance): write addr=13 16'hBEEF, read addr=13 -> rdata=0; addr 0..11 unaffected.
